id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined CPU. It registers decoded operands and control from the decode stage and presents them to the execute stage (ALU, shifter, branch compare). It detects load-use hazards and inserts bubbles, and supports flush and downstream stall. It also resolves the shift amount for the execute-stage shifter, so the shifter receives a ready 5-bit amount.

---
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It captures decoded operands and control for the
// execute stage, detects load-use hazards and inserts one-cycle bubbles, and
// honours flush and the downstream stall. It also resolves the shifter amount
// (SLLV takes it from rs) so execute receives a ready 5-bit value.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [5:0]        id_funct,
   input  logic [7:0]        id_ctrl,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_wreg,
   output logic [4:0]        ex_shift_amt,
   output logic [5:0]        ex_funct,
   output logic [7:0]        ex_ctrl,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [5:0] FunctSllv = 6'b000100;
   localparam logic [1:0] AluOpRType = 2'b10;

   logic             loadUse;
   logic [REG_W-1:0] idWreg;
   logic [4:0]       idShiftAmt;

   // Load in EX whose destination is read by the ID instruction. rt only
   // counts when ID actually uses it as a register operand (alu_src clear).
   always_comb begin
      loadUse = ex_valid & ex_ctrl[1] & (ex_wreg != '0) & id_valid &
                ((ex_wreg == id_rs) | ((ex_wreg == id_rt) & ~id_ctrl[4]));
   end

   // A flush or a held stage makes the bubble moot, so the stall is masked.
   assign hazard_stall = loadUse & ~flush & ~ext_stall;

   // Destination select and shifter-amount resolution ahead of the register.
   always_comb begin
      idWreg     = id_ctrl[5] ? id_rd : id_rt;
      idShiftAmt = id_shamt;
      if ((id_funct == FunctSllv) && (id_ctrl[7:6] == AluOpRType)) begin
         idShiftAmt = id_rs_data[4:0];
      end
   end

   // Stage register: downstream stall holds, then flush, then load-use bubble,
   // otherwise capture the decode stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_rs_data   <= '0;
         ex_rt_data   <= '0;
         ex_imm       <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_wreg      <= '0;
         ex_shift_amt <= '0;
         ex_funct     <= '0;
         ex_ctrl      <= '0;
         bubble_cnt   <= '0;
      end else if (ext_stall) begin
         ex_valid <= ex_valid;
      end else if (flush || hazard_stall) begin
         ex_valid     <= 1'b0;
         ex_rs_data   <= '0;
         ex_rt_data   <= '0;
         ex_imm       <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_wreg      <= '0;
         ex_shift_amt <= '0;
         ex_funct     <= '0;
         ex_ctrl      <= '0;
         if (!flush) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         ex_valid     <= id_valid;
         ex_rs_data   <= id_rs_data;
         ex_rt_data   <= id_rt_data;
         ex_imm       <= id_imm;
         ex_rs        <= id_rs;
         ex_rt        <= id_rt;
         ex_wreg      <= idWreg;
         ex_shift_amt <= idShiftAmt;
         ex_funct     <= id_funct;
         ex_ctrl      <= id_valid ? id_ctrl : 8'h00;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          extStall, flush, idValid;
   logic [DW-1:0] idRsData, idRtData, idImm;
   logic [RW-1:0] idRs, idRt, idRd;
   logic [4:0]    idShamt;
   logic [5:0]    idFunct;
   logic [7:0]    idCtrl;
   logic          hazardStall, exValid;
   logic [DW-1:0] exRsData, exRtData, exImm;
   logic [RW-1:0] exRs, exRt, exWreg;
   logic [4:0]    exShiftAmt;
   logic [5:0]    exFunct;
   logic [7:0]    exCtrl;
   logic [CW-1:0] bubbleCnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit      valid;
      longint  rsData, rtData, imm;
      int      rs, rt, wreg, shamt, funct, ctrl;
      int      bubbles;
   } stage_t;

   stage_t m;

   id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ext_stall(extStall), .flush(flush),
      .id_valid(idValid), .id_rs_data(idRsData), .id_rt_data(idRtData),
      .id_imm(idImm), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
      .id_shamt(idShamt), .id_funct(idFunct), .id_ctrl(idCtrl),
      .hazard_stall(hazardStall), .ex_valid(exValid),
      .ex_rs_data(exRsData), .ex_rt_data(exRtData), .ex_imm(exImm),
      .ex_rs(exRs), .ex_rt(exRt), .ex_wreg(exWreg),
      .ex_shift_amt(exShiftAmt), .ex_funct(exFunct), .ex_ctrl(exCtrl),
      .bubble_cnt(bubbleCnt)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void modelClear();
      m = '{default: 0};
   endfunction

   function automatic bit modelHazard();
      bit srcHit;
      srcHit = (m.wreg == int'(idRs)) || ((m.wreg == int'(idRt)) && !idCtrl[4]);
      return m.valid && ((m.ctrl & 2) != 0) && (m.wreg != 0) && idValid &&
             srcHit && !flush && !extStall;
   endfunction

   function automatic void modelEdge(input bit hz);
      int keepBubbles;
      if (extStall) return;
      keepBubbles = m.bubbles;
      if (flush || hz) begin
         modelClear();
         m.bubbles = flush ? keepBubbles : (keepBubbles + 1) % (1 << CW);
         return;
      end
      m.valid  = idValid;
      m.rsData = longint'(idRsData);
      m.rtData = longint'(idRtData);
      m.imm    = longint'(idImm);
      m.rs     = int'(idRs);
      m.rt     = int'(idRt);
      m.wreg   = idCtrl[5] ? int'(idRd) : int'(idRt);
      m.funct  = int'(idFunct);
      m.ctrl   = idValid ? int'(idCtrl) : 0;
      m.shamt  = (int'(idFunct) == 4 && int'(idCtrl) / 64 == 2) ?
                 int'(idRsData % 32) : int'(idShamt);
   endfunction

   task automatic checkOutputs();
      checkVal("ex_valid", longint'(exValid), longint'(m.valid));
      checkVal("ex_rs_data", longint'(exRsData), m.rsData);
      checkVal("ex_rt_data", longint'(exRtData), m.rtData);
      checkVal("ex_imm", longint'(exImm), m.imm);
      checkVal("ex_rs", longint'(exRs), longint'(m.rs));
      checkVal("ex_rt", longint'(exRt), longint'(m.rt));
      checkVal("ex_wreg", longint'(exWreg), longint'(m.wreg));
      checkVal("ex_shift_amt", longint'(exShiftAmt), longint'(m.shamt));
      checkVal("ex_funct", longint'(exFunct), longint'(m.funct));
      checkVal("ex_ctrl", longint'(exCtrl), longint'(m.ctrl));
      checkVal("bubble_cnt", longint'(bubbleCnt), longint'(m.bubbles));
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      bit hz;
      #1;
      hz = modelHazard();
      checkVal("hazard_stall", longint'(hazardStall), longint'(hz));
      @(posedge clk);
      modelEdge(hz);
      @(negedge clk);
      checkOutputs();
   endtask

   task automatic setIn(input bit v, input logic [DW-1:0] rsd, input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                        input logic [4:0] sh, input logic [5:0] fn, input logic [7:0] ctl);
      idValid = v; idRsData = rsd; idRtData = DW'($urandom); idImm = DW'($urandom);
      idRs = rs; idRt = rt; idRd = rd; idShamt = sh; idFunct = fn; idCtrl = ctl;
   endtask

   function automatic logic [RW-1:0] pickIdx();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return RW'(8);
         2: return RW'(9);
         default: return RW'($urandom);
      endcase
   endfunction

   task automatic randomIn();
      logic [7:0] c;
      c = 8'($urandom);
      if ($urandom_range(0, 1) == 1) c[1] = 1'b1;
      setIn($urandom_range(0, 4) != 0, DW'($urandom), pickIdx(), pickIdx(), pickIdx(),
            5'($urandom), ($urandom_range(0, 1) == 1) ? 6'd4 : 6'($urandom), c);
      flush    = ($urandom_range(0, 7) == 0);
      extStall = ($urandom_range(0, 5) == 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic midReset();
      #2 rst = 1'b1;
      #1;
      modelClear();
      checkOutputs();
      checkVal("rst_hazard", longint'(hazardStall), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   localparam logic [7:0] CtrlLw  = 8'h1B;  // reg_write mem_read mem_to_reg alu_src
   localparam logic [7:0] CtrlAdd = 8'hA1;  // reg_write reg_dst alu_op=R

   initial begin
      rst = 1'b1; extStall = 1'b0; flush = 1'b0;
      setIn(1'b0, '0, '0, '0, '0, '0, '0, '0);
      modelClear();
      repeat (2) @(negedge clk);
      checkOutputs();
      rst = 1'b0;

      // Pass-through of an SLL.
      setIn(1'b1, 32'h1234_5678, 5'd1, 5'd2, 5'd3, 5'd3, 6'd0, CtrlAdd);
      cycle();
      checkVal("pass_rs_data", longint'(exRsData), 64'h1234_5678);
      checkVal("pass_shamt", longint'(exShiftAmt), 3);
      checkVal("pass_valid", longint'(exValid), 1);

      // SLLV takes its amount from rs_data[4:0].
      setIn(1'b1, 32'h0000_0027, 5'd1, 5'd2, 5'd3, 5'd9, 6'b000100, CtrlAdd);
      cycle();
      checkVal("sllv_shamt", longint'(exShiftAmt), 7);

      // Stage full, then an asynchronous reset.
      midReset();

      // Load-use: lw r8, then add using r8.
      setIn(1'b1, 32'h10, 5'd4, 5'd8, 5'd0, 5'd0, 6'd0, CtrlLw);
      cycle();
      setIn(1'b1, 32'h20, 5'd8, 5'd5, 5'd6, 5'd0, 6'h20, CtrlAdd);
      #1 checkVal("lu_hazard", longint'(hazardStall), 1);
      cycle();
      checkVal("lu_bubble_valid", longint'(exValid), 0);
      checkVal("lu_bubble_ctrl", longint'(exCtrl), 0);
      checkVal("lu_bubble_cnt", longint'(bubbleCnt), 1);
      #1 checkVal("lu_hazard_clear", longint'(hazardStall), 0);
      cycle();
      checkVal("lu_add_valid", longint'(exValid), 1);
      checkVal("lu_add_ctrl", longint'(exCtrl), longint'(CtrlAdd));

      // Flush beats the hazard and counts no bubble.
      setIn(1'b1, 32'h10, 5'd4, 5'd8, 5'd0, 5'd0, 6'd0, CtrlLw);
      cycle();
      setIn(1'b1, 32'h20, 5'd8, 5'd5, 5'd6, 5'd0, 6'h20, CtrlAdd);
      flush = 1'b1;
      #1 checkVal("fl_hazard", longint'(hazardStall), 0);
      cycle();
      flush = 1'b0;
      checkVal("fl_valid", longint'(exValid), 0);
      checkVal("fl_cnt", longint'(bubbleCnt), 1);

      // Downstream stall holds the lw while ID churns; hazard shows on release.
      setIn(1'b1, 32'h10, 5'd4, 5'd8, 5'd0, 5'd0, 6'd0, CtrlLw);
      cycle();
      for (int i = 0; i < 3; i++) begin
         setIn(1'b1, DW'($urandom), 5'd8, 5'($urandom), 5'($urandom), 5'($urandom),
               6'($urandom), CtrlAdd);
         extStall = 1'b1;
         flush = (i == 1);
         #1 checkVal("es_hazard", longint'(hazardStall), 0);
         cycle();
         checkVal("es_hold_ctrl", longint'(exCtrl), longint'(CtrlLw));
      end
      extStall = 1'b0; flush = 1'b0;
      #1 checkVal("es_release_hazard", longint'(hazardStall), 1);
      cycle();

      // Randomized traffic, with occasional asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         randomIn();
         if ($urandom_range(0, 499) == 0) begin
            midReset();
         end else begin
            cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
